// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce and optional auto-repeat.
// Latency: a press is reported after deb stable scan ticks (plus synchronizer and column search).
// Flow control: none; key_valid is a one-cycle strobe and the consumer must take it that cycle.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   row[3:0]   keypad rows, active-low, asynchronous to clk
//   col[3:0]   column drive, exactly one bit low
//   key_code   accepted key = row_idx*4 + col_idx, held until the next accepted press
//   key_valid  one-cycle strobe, key_code valid in the same cycle
//   key_held   high while the accepted key is still pressed (covers release debounce)
//
// Parameters: div = clocks per scan tick, deb = stable ticks to accept a press/release,
// rep = ticks between auto-repeat strobes.
// Optional feature: define KEYPAD_REPEAT_EN to emit repeat strobes while a key is held.
//
// Note: the row synchronizer is two clocks deep, so a row read reflects the column
// driven two clocks earlier. With div >= 3 every tick sees a settled column.

module keypad_scanner #(
  parameter int div = 100,
  parameter int deb = 4,
  parameter int rep = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  // Elaboration-time parameter sanity checks.
  if (div < 2 || div > (1 << 20)) begin : g_div_range
    $error("keypad_scanner: div must be within 2..2^20");
  end
  if (deb < 2 || deb > 15) begin : g_deb_range
    $error("keypad_scanner: deb must be within 2..15");
  end
  if (rep < 1) begin : g_rep_range
    $error("keypad_scanner: rep must be at least 1");
  end

  localparam int            TW        = (div > 1) ? $clog2(div) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(div - 1);
  localparam logic [3:0]    STAB_LAST = 4'(deb - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // ------------------------------------------------------------------
  // Row synchronizer: rows idle high, so reset to all-ones (no key).
  // ------------------------------------------------------------------
  logic [3:0] row_meta;
  logic [3:0] rs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta <= 4'b1111;
      rs       <= 4'b1111;
    end else begin
      row_meta <= row;
      rs       <= row_meta;
    end
  end

  // ------------------------------------------------------------------
  // Scan tick: one-cycle pulse every div clocks.
  // ------------------------------------------------------------------
  logic [TW-1:0] tcnt;
  logic          tick;

  assign tick = (tcnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt <= '0;
    end else if (tick) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // Index encoders.
  // ------------------------------------------------------------------
  logic [1:0] col_idx;   // position of the driven (low) column
  logic [1:0] row_idx;   // lowest-index low row; lower rows win on multi-press

  always_comb begin
    col_idx = 2'd0;
    row_idx = 2'd0;
    // Walk downwards so the last hit is the lowest index.
    for (int i = 3; i >= 0; i--) begin
      if (!col[i]) col_idx = 2'(i);
      if (!rs[i])  row_idx = 2'(i);
    end
  end

  // ------------------------------------------------------------------
  // Scan / debounce FSM with registered outputs.
  // ------------------------------------------------------------------
  state_t     state;
  logic [1:0] lat_row;
  logic [1:0] lat_col;
  logic [3:0] stab;
  logic [3:0] stab_inc;
  logic       key_down;

  assign stab_inc = stab + 4'd1;
  // Only the latched row is watched once a key is captured; other keys are ignored.
  assign key_down = ~rs[lat_row];

`ifdef KEYPAD_REPEAT_EN
  localparam int            RW       = (rep > 1) ? $clog2(rep) : 1;
  localparam logic [RW-1:0] RPT_LAST = RW'(rep - 1);
  logic [RW-1:0] rpt;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SCAN;
      col       <= 4'b1110;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      stab      <= 4'd0;
      lat_row   <= 2'd0;
      lat_col   <= 2'd0;
`ifdef KEYPAD_REPEAT_EN
      rpt       <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        unique case (state)
          SCAN: begin
            if (rs == 4'b1111) begin
              col <= {col[2:0], col[3]};
            end else begin
              // Column stays frozen on the one that produced the low row.
              lat_row <= row_idx;
              lat_col <= col_idx;
              stab    <= 4'd0;
              state   <= DEBOUNCE;
            end
          end

          DEBOUNCE: begin
            if (!key_down) begin
              state <= SCAN;
            end else if (stab_inc == STAB_LAST) begin
              // The detection tick plus deb-1 further low ticks: accept.
              stab      <= stab_inc;
              key_code  <= {lat_row, lat_col};
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              state     <= HELD;
`ifdef KEYPAD_REPEAT_EN
              rpt       <= '0;
`endif
            end else begin
              stab <= stab_inc;
            end
          end

          HELD: begin
            if (!key_down) begin
              stab  <= 4'd0;
              state <= RELEASE;
`ifdef KEYPAD_REPEAT_EN
            end else if (rpt == RPT_LAST) begin
              rpt       <= '0;
              key_valid <= 1'b1;
            end else begin
              rpt <= rpt + 1'b1;
`endif
            end
          end

          RELEASE: begin
            if (key_down) begin
              // Release bounce: resume holding without a new strobe. The repeat
              // counter keeps its value so the repeat cadence is not restarted.
              state <= HELD;
            end else if (stab_inc == STAB_LAST) begin
              key_held <= 1'b0;
              state    <= SCAN;
            end else begin
              stab <= stab_inc;
            end
          end

          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scoreboard bench for keypad_scanner with a 4x4 key-matrix model.
// Expected key codes are queued when a key is pressed and popped on each key_valid.
module tb_keypad_scanner;

  localparam int DIV     = 4;
  localparam int DEB     = 4;
  localparam int REP     = 8;
  localparam int LAT_MAX = (DEB + 1) * DIV + 4 * DIV + 2;
  localparam int WAIT_LIM = LAT_MAX + 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] pressed;       // pressed[r*4+c] closes the switch at row r, column c
  logic [3:0]  exp_q[$];
  int          checks  = 0;
  int          errors  = 0;
  int          strobes = 0;
  int          pushes  = 0;
  bit          mon_on  = 1'b0;

  keypad_scanner #(
    .div(DIV),
    .deb(DEB),
    .rep(REP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // Matrix model: a closed switch pulls its row low when its column is driven low.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_key(input logic [3:0] code);
    exp_q.push_back(code);
    pushes++;
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (mon_on) begin
      check("col_one_low", $countones(~col), 1);
      if (key_valid) begin
        strobes++;
        if (exp_q.size() == 0) check("unexpected_strobe", key_valid, 0);
        else                   check("key_code", key_code, exp_q.pop_front());
      end
    end
  end

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    clocks(n * DIV);
  endtask

  // Wait for the next strobe; lat = clocks waited, -1 on timeout.
  task automatic wait_strobe(input string tag, input int limit, output int lat);
    int s0;
    s0  = strobes;
    lat = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      #1;
      if (strobes != s0) begin
        lat = i;
        break;
      end
    end
    check({tag, "_strobe_in_time"}, int'(lat > 0), 1);
  endtask

  task automatic wait_release(input string tag);
    int i;
    for (i = 0; i < 60 && key_held; i++) begin
      @(negedge clk);
      #1;
    end
    check({tag, "_released"}, key_held, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int s0;
    rst     = 1'b0;
    pressed = '0;

    // Reset state.
    clocks(3);
    #1;
    check("rst_col", col, 4'b1110);
    check("rst_code", key_code, 0);
    check("rst_valid", key_valid, 0);
    check("rst_held", key_held, 0);
    mon_on = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    ticks(3);
    check("idle_not_held", key_held, 0);

    // Single press at row 2 / col 1 held for 100 ticks.
    s0 = strobes;
    pressed[9] = 1'b1;
    expect_key(4'd9);
    wait_strobe("press", WAIT_LIM, lat);
    check("press_debounced", int'(lat >= 3 * DIV), 1);
    check("press_held", key_held, 1);
    ticks(90);
    check("press_one_strobe", strobes - s0, 1);
    check("press_still_held", key_held, 1);
    pressed[9] = 1'b0;
    clocks(8);
    check("release_debounce_held", key_held, 1);
    check("code_kept", key_code, 9);
    clocks(16);
    check("release_done", key_held, 0);
    check("code_kept_idle", key_code, 9);
    ticks(2);

    // Bouncing contact: no strobe while toggling, one strobe once stable.
    for (int i = 0; i < 10; i++) begin
      pressed[2] = (i % 2 == 0);
      ticks(1);
    end
    s0 = strobes;
    pressed[2] = 1'b1;
    expect_key(4'd2);
    wait_strobe("bounce", WAIT_LIM, lat);
    check("bounce_min_latency", int'(lat >= 3 * DIV), 1);
    ticks(6);
    check("bounce_one_strobe", strobes - s0, 1);
    pressed[2] = 1'b0;
    wait_release("bounce");
    ticks(2);

    // Rows 1 and 3 on column 0: lowest row wins.
    pressed[4]  = 1'b1;
    pressed[12] = 1'b1;
    expect_key(4'd4);
    wait_strobe("multi", WAIT_LIM, lat);
    ticks(4);
    pressed[4]  = 1'b0;
    pressed[12] = 1'b0;
    wait_release("multi");
    ticks(2);

    // Release glitch: one low tick during release debounce.
    s0 = strobes;
    pressed[15] = 1'b1;
    expect_key(4'd15);
    wait_strobe("glitch", WAIT_LIM, lat);
    ticks(5);
    pressed[15] = 1'b0;
    ticks(2);
    pressed[15] = 1'b1;
    ticks(1);
    pressed[15] = 1'b0;
    clocks(10);
    check("glitch_still_held", key_held, 1);
    wait_release("glitch");
    check("glitch_one_strobe", strobes - s0, 1);
    ticks(2);

    // Reset while held; key kept pressed is detected afresh.
    pressed[5] = 1'b1;
    expect_key(4'd5);
    wait_strobe("rst_held", WAIT_LIM, lat);
    ticks(3);
    rst = 1'b0;
    #1;
    check("midrst_held", key_held, 0);
    check("midrst_valid", key_valid, 0);
    check("midrst_code", key_code, 0);
    check("midrst_col", col, 4'b1110);
    clocks(2);
    @(negedge clk);
    rst = 1'b1;
    s0 = strobes;
    expect_key(4'd5);
    wait_strobe("rst_fresh", WAIT_LIM, lat);
    check("rst_fresh_count", strobes - s0, 1);
    pressed[5] = 1'b0;
    wait_release("rst_fresh");
    ticks(2);

    // Long hold of key 0: repeat strobes only with the repeat build.
    s0 = strobes;
    pressed[0] = 1'b1;
    expect_key(4'd0);
    wait_strobe("hold", WAIT_LIM, lat);
`ifdef KEYPAD_REPEAT_EN
    for (int i = 0; i < 3; i++) expect_key(4'd0);
`endif
    ticks(30);
`ifdef KEYPAD_REPEAT_EN
    check("hold_strobes", strobes - s0, 4);
`else
    check("hold_strobes", strobes - s0, 1);
`endif
    pressed[0] = 1'b0;
    wait_release("hold");
    ticks(4);

    check("queue_drained", exp_q.size(), 0);
    check("total_strobes", strobes, pushes);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter div, default 100: system clocks per scan tick; legal range 2..2^20.
REQ-002 Parameter deb, default 4: consecutive stable ticks required to accept a press or a release; legal range 2..15.
REQ-003 Parameter rep, default 32: ticks between auto-repeat strobes; used only when KEYPAD_REPEAT_EN is defined.
REQ-004 clk  in  1  system clock; all flops rising-edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 row  in  4  keypad row lines, active-low, externally pulled up; asynchronous to clk.
REQ-007 col  out  4  column drive, exactly one bit low at all times.
REQ-008 key_code  out  4  accepted key = row_idx*4 + col_idx, where idx = bit position 0..3.
REQ-009 key_valid  out  1  one-clk strobe; key_code is valid in the same cycle.
REQ-010 key_held  out  1  high while an accepted key remains pressed.

Function
REQ-011 row SHALL pass through a 2-flop synchronizer (reset value 4'b1111); all decisions use the synchronized value rs.
REQ-012 Tick counter SHALL count 0..div-1 and wrap; tick is a one-clk pulse when the count equals div-1.
REQ-013 FSM states SHALL be SCAN, DEBOUNCE, HELD, RELEASE; all state changes occur only on tick cycles.
REQ-014 SCAN, on each tick: if rs==4'b1111, rotate col 1110->1101->1011->0111->1110; else latch col index and the lowest-index low row bit, clear the stable counter, freeze col, go to DEBOUNCE.
REQ-015 DEBOUNCE, on each tick: if the latched row bit is low, increment the stable counter; if it is high, go to SCAN (col resumes rotating from the frozen value on the next tick).
REQ-016 When the stable counter reaches deb-1, the next clock SHALL assert key_valid for exactly one cycle with key_code updated, and the FSM SHALL enter HELD.
REQ-017 HELD: key_held=1 and col stays frozen; on a tick with the latched row bit high, clear the counter and go to RELEASE.
REQ-018 RELEASE: key_held stays 1; each tick with the latched bit high increments the counter; reaching deb-1 goes to SCAN with key_held=0; any tick with the bit low returns to HELD with no new strobe.
REQ-019 Additional keys pressed while in DEBOUNCE/HELD/RELEASE SHALL be ignored; only the latched row/col pair is monitored.
REQ-020 key_code SHALL hold its last accepted value until the next accepted press.
REQ-021 Maximum press latency from rs going low: (deb+1)*div + 4*div + 2 clocks.

Reset
REQ-022 Asserting rst (low) SHALL immediately force state=SCAN, col=4'b1110, key_code=0, key_valid=0, key_held=0, tick and stable counters to 0, synchronizer to 4'b1111.
REQ-023 Reset mid-press SHALL produce no strobe on release; a still-held key after rst deasserts SHALL be re-detected as a new press via SCAN.

Configuration
REQ-024 Macro KEYPAD_REPEAT_EN: when defined, in HELD a repeat counter SHALL emit key_valid (same key_code) every rep ticks, the first repeat rep ticks after entry to HELD; the counter resets on entry to HELD and is held in RELEASE.
REQ-025 Without KEYPAD_REPEAT_EN, exactly one key_valid strobe SHALL be emitted per accepted press, and no repeat logic SHALL be present.

Verification (div=4, deb=4, rep=8)
REQ-026 Press key at row 2/col 1 for 100 ticks -> one key_valid with key_code=4'd9, key_held high until deb ticks after release.
REQ-027 Bounce: row toggles low/high every tick for 10 ticks, then stays low -> no strobe during bouncing, exactly one strobe after 4 stable ticks.
REQ-028 Rows 1 and 3 low simultaneously on col 0 -> key_code=4'd4 (lowest row wins).
REQ-029 Release glitch: during RELEASE, bit returns low for 1 tick -> back to HELD, no second strobe, key_held stays 1.
REQ-030 rst pulsed low while HELD -> outputs at reset values within one clk of rst falling; key kept pressed -> fresh strobe after rst rises.
REQ-031 With KEYPAD_REPEAT_EN, hold key 0 for 30 ticks after acceptance -> strobes at acceptance, +8, +16, +24 ticks, all key_code=0; without the macro -> single strobe.
